// File: rtl/sevseg_scan_ctrl.sv
// sevseg_scan_ctrl: time-multiplexed scan controller for an N-digit
// common-anode 7-segment display with a frame-synchronous load handshake.
// Optional feature macro: SEVSEG_LEADING_ZERO_BLANK_EN (leading-zero blanking).
module sevseg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    localparam int unsigned IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int unsigned DATA_W      = 4 * NUM_DIGITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic [NUM_DIGITS-1:0] digit_en,
    output logic [3:0]        bcd_out,
    output logic [NUM_DIGITS-1:0] anode_n,
    output logic [IDX_W-1:0]  scan_idx,
    output logic              frame_tick
);

    localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    // State and datapath registers
    logic [0:0]            r_state;
    logic [CNT_W-1:0]      r_div_cnt;
    logic [IDX_W-1:0]      r_scan_idx;
    logic [DATA_W-1:0]     r_active;
    logic [DATA_W-1:0]     r_shadow;
    logic                  r_pending;
    logic [NUM_DIGITS-1:0] r_anode_n;
    logic [3:0]            r_bcd_out;
    logic                  r_frame_tick;

    // Next-state / decode signals
    logic                  w_blank_done;
    logic                  w_show_done;
    logic                  w_last_idx;
    logic                  w_wrap;
    logic                  w_swap;
    logic                  w_xfer;
    logic [0:0]            w_next_state;
    logic [CNT_W-1:0]      w_next_cnt;
    logic [IDX_W-1:0]      w_next_idx;
    logic [DATA_W-1:0]     w_next_active;
    logic [3:0]            w_nib;
    logic [NUM_DIGITS-1:0] w_lz_dark;
    logic [NUM_DIGITS-1:0] w_anode_show;
    logic [NUM_DIGITS-1:0] w_next_anode_n;
    logic [3:0]            w_next_bcd;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    logic                  w_upper_zero;
`endif

    // Phase-end, frame-boundary and handshake qualifiers
    assign w_blank_done  = (r_state == ST_BLANK) && (r_div_cnt == CNT_W'(BLANK_CYCLES - 1));
    assign w_show_done   = (r_state == ST_SHOW)  && (r_div_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_last_idx    = (r_scan_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_wrap        = w_blank_done && w_last_idx;
    // Swap uses the pre-edge pending flag, so a same-edge transfer waits a frame
    assign w_swap        = w_wrap && r_pending;
    assign w_xfer        = load_valid && !r_pending;
    assign w_next_active = w_swap ? r_shadow : r_active;

    // Next state, divider and scan index
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_div_cnt + CNT_W'(1);
        w_next_idx   = r_scan_idx;
        if (w_blank_done) begin
            w_next_state = ST_SHOW;
            w_next_cnt   = '0;
            w_next_idx   = w_last_idx ? '0 : (r_scan_idx + IDX_W'(1));
        end else if (w_show_done) begin
            w_next_state = ST_BLANK;
            w_next_cnt   = '0;
        end
    end

    // Nibble for the digit being shown next cycle (from the post-swap frame)
    always_comb begin
        w_nib = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IDX_W'(k) == w_next_idx) begin
                w_nib = w_next_active[4*k +: 4];
            end
        end
    end

    // Leading-zero dark mask: digit k>0 is dark when nibbles k..top are all zero
    always_comb begin
        w_lz_dark = '0;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        w_upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_upper_zero = w_upper_zero && (w_next_active[4*k +: 4] == 4'h0);
            w_lz_dark[k] = (k > 0) && w_upper_zero;
        end
`endif
    end

    // Anode pattern while showing: only the selected, enabled, non-blanked digit
    always_comb begin
        w_anode_show = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((IDX_W'(k) == w_next_idx) && digit_en[k] && !w_lz_dark[k]) begin
                w_anode_show[k] = 1'b0;
            end
        end
    end

    // Output decode for the next cycle; bcd_out holds its value while blanking
    always_comb begin
        w_next_anode_n = '1;
        w_next_bcd     = r_bcd_out;
        if (w_next_state == ST_SHOW) begin
            w_next_anode_n = w_anode_show;
            w_next_bcd     = w_nib;
        end
    end

    // State, frame buffer, handshake and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_BLANK;
            r_div_cnt    <= '0;
            r_scan_idx   <= IDX_W'(NUM_DIGITS - 1);
            r_active     <= '0;
            r_shadow     <= '0;
            r_pending    <= 1'b0;
            r_anode_n    <= '1;
            r_bcd_out    <= 4'h0;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_div_cnt    <= w_next_cnt;
            r_scan_idx   <= w_next_idx;
            r_active     <= w_next_active;
            r_anode_n    <= w_next_anode_n;
            r_bcd_out    <= w_next_bcd;
            r_frame_tick <= w_wrap;
            if (w_swap) begin
                r_pending <= 1'b0;
            end else if (w_xfer) begin
                r_shadow  <= load_data;
                r_pending <= 1'b1;
            end
        end
    end

    assign load_ready = !r_pending;
    assign bcd_out    = r_bcd_out;
    assign anode_n    = r_anode_n;
    assign scan_idx   = r_scan_idx;
    assign frame_tick = r_frame_tick;

endmodule
